shift_normalizer: RTL and testbench

- Iterative normalizer for the ALU shift datapath; the inverse of the barrel shifter.
- Takes an operand and left-shifts it one bit per cycle until it is normalized.
- Returns the normalized value Y and the shift count CNT, such that right-shifting Y by CNT restores A: logical right for MODE=0, arithmetic right for MODE=1.
- Used by count-leading-zeros/sign support and FP-style normalization sequences; sits beside the ALU under a start/done handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/shift_normalizer_norm_detect.sv | 31 +++
 rtl/shift_normalizer.sv | 114 +++++++++++
 tb/tb_shift_normalizer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift datapath (barrel shifter and the
// iterative shift normalizer).
//   - NORM_UNSIGNED / NORM_SIGNED : normalizer MODE encodings
//   - norm_state_e                : normalizer FSM state encoding
//   - NORM_WIDTH / NORM_CNT_W     : default operand and shift-count widths
package alu_pkg;

    localparam int NORM_WIDTH = 32;
    localparam int NORM_CNT_W = 5;

    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } norm_state_e;

endpackage

// File: rtl/shift_normalizer_norm_detect.sv
// norm_detect: combinational normalization test for one operand value.
//   y       : candidate value
//   mode    : NORM_UNSIGNED or NORM_SIGNED
//   is_norm : unsigned -> MSB set; signed -> top two bits differ
//   is_zero : value can never be normalized (unsigned: 0; signed: 0 or all ones)
module norm_detect
    import alu_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH
) (
    input  logic [WIDTH-1:0] y,
    input  logic             mode,
    output logic             is_norm,
    output logic             is_zero
);

    always_comb begin
        is_norm = 1'b0;
        is_zero = 1'b0;
        if (mode == NORM_SIGNED) begin
            // 0 and -1 consist purely of sign bits; no shift ever separates
            // the top two bits.
            is_zero = (y == '0) || (y == '1);
            is_norm = y[WIDTH-1] ^ y[WIDTH-2];
        end else begin
            is_zero = (y == '0);
            is_norm = y[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative normalizer, one left shift per cycle, under a
// START/DONE handshake. Right-shifting Y by CNT (logical for MODE=0,
// arithmetic for MODE=1) restores the original operand A.
// CNT_W must equal $clog2(WIDTH).
// Ports:
//   CLK, RESET_N : clock, asynchronous active-low reset
//   START, MODE  : request and normalization mode (accepted when READY=1)
//   A            : operand, sampled on the accepting edge
//   READY        : high in IDLE and DONE
//   DONE         : one-cycle pulse, result valid
//   Y, CNT, ZERO : normalized value, shift count, unnormalizable flag;
//                  held until the next accepted START
module shift_normalizer
    import alu_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int CNT_W = NORM_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic [CNT_W-1:0] CNT,
    output logic             ZERO
);

    norm_state_e      state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic is_norm;
    logic is_zero;

    norm_detect #(.WIDTH(WIDTH)) u_detect (
        .y       (y_q),
        .mode    (mode_q),
        .is_norm (is_norm),
        .is_zero (is_zero)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    y_d     = A;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    mode_d  = MODE;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The unnormalizable check wins so Y keeps A and CNT stays 0.
                if (is_zero) begin
                    zero_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (is_norm) begin
                    state_d = ST_DONE;
                end else begin
                    y_d   = y_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered, derived from the next state.
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d != ST_SHIFT);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            mode_q  <= NORM_UNSIGNED;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign READY = ready_q;
    assign DONE  = done_q;
    assign Y     = y_q;
    assign CNT   = cnt_q;
    assign ZERO  = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

    localparam int W  = 32;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          MODE = 1'b0;
    logic [W-1:0]  A = '0;
    logic          READY, DONE, ZERO;
    logic [W-1:0]  Y;
    logic [CW-1:0] CNT;

    shift_normalizer #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .MODE(MODE), .A(A),
        .READY(READY), .DONE(DONE), .Y(Y), .CNT(CNT), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  a;
        logic          m;
        logic [W-1:0]  y;
        logic [CW-1:0] cnt;
        logic          zero;
        int            due;
    } exp_t;

    exp_t q[$];
    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
    function automatic exp_t model(logic [W-1:0] a, logic m);
        exp_t e;
        int lead = 0;
        e.a = a; e.m = m; e.due = 0;
        if (!m) begin
            for (int i = W-1; i >= 0 && a[i] == 1'b0; i--) lead++;
            e.zero = (lead == W);
            e.cnt  = e.zero ? '0 : CW'(lead);
        end else begin
            for (int i = W-1; i >= 0 && a[i] == a[W-1]; i--) lead++;
            e.zero = (lead == W);
            e.cnt  = e.zero ? '0 : CW'(lead - 1);
        end
        e.y = a << e.cnt;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(logic [W-1:0] a, logic m, bit track);
        int t = 0;
        exp_t e;
        while (!READY && t < 100) begin @(negedge CLK); t++; end
        if (!READY) begin
            check("ready_timeout", 64'(READY), 64'd1);
            return;
        end
        START = 1'b1; A = a; MODE = m;
        if (track) begin
            e = model(a, m);
            e.due = cyc + 1 + int'(e.cnt) + 1;
            q.push_back(e);
        end
        @(negedge CLK);
        START = 1'b0;
        A = $urandom;
        MODE = 1'($urandom_range(0, 1));
    endtask

    // Monitor: checks every DONE against the scoreboard, and hold in IDLE.
    exp_t          mon_e;
    logic [W-1:0]  last_y = '0;
    logic [CW-1:0] last_cnt = '0;
    logic          last_zero = 1'b0;
    logic [W-1:0]  restored;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            last_y = '0; last_cnt = '0; last_zero = 1'b0;
        end else if (DONE) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("y", 64'(Y), 64'(mon_e.y));
                check("cnt", 64'(CNT), 64'(mon_e.cnt));
                check("zero", 64'(ZERO), 64'(mon_e.zero));
                check("latency", 64'(cyc), 64'(mon_e.due));
                check("ready_in_done", 64'(READY), 64'd1);
                if (mon_e.m) restored = W'($signed(Y) >>> CNT);
                else         restored = Y >> CNT;
                check("restore", 64'(restored), 64'(mon_e.a));
            end
            last_y = Y; last_cnt = CNT; last_zero = ZERO;
        end else if (READY) begin
            check("hold", 64'({ZERO, CNT, Y}), 64'({last_zero, last_cnt, last_y}));
        end
    end

    initial begin
        int t;
        logic [W-1:0] ra;
        logic rm;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_ready", 64'(READY), 64'd1);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_y_cnt_zero", 64'({ZERO, CNT, Y}), 64'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Reset mid-SHIFT: asynchronous clear, no DONE afterwards
        issue(32'h0000_0001, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_y", 64'(Y), 64'd0);
        check("arst_cnt", 64'(CNT), 64'd0);
        check("arst_ready", 64'(READY), 64'd1);
        check("arst_done", 64'(DONE), 64'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (40) @(negedge CLK);

        // Directed corners
        issue(32'h0000_0001, 1'b0, 1'b1);   // n=31
        issue(32'hFFFF_F000, 1'b1, 1'b1);   // n=19
        issue(32'h0000_0000, 1'b0, 1'b1);   // ZERO
        issue(32'hFFFF_FFFF, 1'b1, 1'b1);   // ZERO
        issue(32'h0000_0000, 1'b1, 1'b1);   // ZERO
        issue(32'h0000_0001, 1'b1, 1'b1);   // n=30
        repeat (3) @(negedge CLK);
        issue(32'h8000_0000, 1'b0, 1'b1);   // n=0
        issue(32'h0001_0000, 1'b0, 1'b1);   // back-to-back, n=15

        // START while busy is ignored
        issue(32'h0000_0100, 1'b0, 1'b1);   // n=23
        repeat (3) @(negedge CLK);
        START = 1'b1; A = 32'h1; MODE = 1'b0;
        @(negedge CLK);
        START = 1'b0;

        // Randomized operands
        for (int i = 0; i < 150; i++) begin
            rm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ra = $urandom >> $urandom_range(0, 31);
                1: ra = ~($urandom >> $urandom_range(0, 31));
                2: ra = $urandom_range(0, 1) ? '1 : '0;
                default: ra = $urandom;
            endcase
            issue(ra, rm, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        t = 0;
        while (q.size() > 0 && t < 200) begin @(negedge CLK); t++; end
        if (q.size() > 0) check("drain", 64'(q.size()), 64'd0);
        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
